// File: rtl/rgb_pl9823_chain.sv
// PL9823 daisy-chain driver: latch gap, then NUM_LEDS x 24 bits MSB first, pixel data prefetched from a latency-1 store.
// Optional build macro RGB_PL9823_AUTO_REFRESH_EN: refresh the chain continuously without START.
module rgb_pl9823_chain #(
  parameter int NUM_LEDS  = 3,
  parameter int BIT_CYC   = 86,
  parameter int T0H_CYC   = 18,
  parameter int T1H_CYC   = 68,
  parameter int RESET_CYC = 3000,
  parameter int ADDR_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic [ADDR_W-1:0] o_pix_addr,
  input  logic [23:0]       i_pix_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_out
);

  localparam int CNT_MAX = (BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  C_BIT_LAST = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0]  C_RST_LAST = CNT_W'(RESET_CYC - 1);
  localparam logic [CNT_W-1:0]  C_T0H      = CNT_W'(T0H_CYC);
  localparam logic [CNT_W-1:0]  C_T1H      = CNT_W'(T1H_CYC);
  localparam logic [ADDR_W-1:0] C_PIX_LAST = ADDR_W'(NUM_LEDS - 1);

  generate
    if (NUM_LEDS < 1 || T0H_CYC < 1 || T0H_CYC >= T1H_CYC || T1H_CYC >= BIT_CYC || RESET_CYC < 1) begin : g_bad_params
      $error("rgb_pl9823_chain: illegal timing or chain-length parameters");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_SEND} state_t;

  state_t            r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic [4:0]        r_bit, w_bit_next;
  logic [ADDR_W-1:0] r_pix, w_pix_next;
  logic [ADDR_W-1:0] r_addr, w_addr_next;
  logic [23:0]       r_shift, w_shift_next;
  logic [23:0]       r_hold, w_hold_next;
  logic              r_busy, w_busy_next;
  logic              r_done, w_done_next;
  logic              r_out, w_out_next;
  logic              w_go;

`ifdef RGB_PL9823_AUTO_REFRESH_EN
  logic w_unused_start;
  assign w_unused_start = i_start;
  assign w_go = 1'b1;
`else
  assign w_go = i_start;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_pix   <= '0;
      r_addr  <= '0;
      r_shift <= '0;
      r_hold  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_out   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bit   <= w_bit_next;
      r_pix   <= w_pix_next;
      r_addr  <= w_addr_next;
      r_shift <= w_shift_next;
      r_hold  <= w_hold_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
      r_out   <= w_out_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_bit_next   = r_bit;
    w_pix_next   = r_pix;
    w_addr_next  = r_addr;
    w_shift_next = r_shift;
    w_hold_next  = r_hold;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_next  = '0;
        w_bit_next  = '0;
        w_pix_next  = '0;
        w_addr_next = '0;
        w_busy_next = w_go;
        if (w_go) begin
          w_state_next = S_LATCH;
        end
      end

      S_LATCH: begin
        if (r_cnt == C_RST_LAST) begin
          w_state_next = S_SEND;
          w_cnt_next   = '0;
          w_shift_next = i_pix_data;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      S_SEND: begin
        if (r_cnt == C_BIT_LAST) begin
          w_cnt_next = '0;
          if (r_bit == 5'd23) begin
            w_bit_next = '0;
            if (r_pix == C_PIX_LAST) begin
              w_state_next = S_IDLE;
              w_busy_next  = 1'b0;
              w_done_next  = 1'b1;
              w_addr_next  = '0;
              w_pix_next   = '0;
            end else begin
              w_pix_next   = r_pix + 1'b1;
              w_shift_next = r_hold;
            end
          end else begin
            w_bit_next   = r_bit + 1'b1;
            w_shift_next = {r_shift[22:0], 1'b0};
            // Entering the last bit of this pixel: request the next one.
            if (r_bit == 5'd22 && r_pix != C_PIX_LAST) begin
              w_addr_next = r_pix + 1'b1;
            end
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
          // Store data for the new address is stable by the second cycle of bit 23.
          if (r_bit == 5'd23 && r_cnt == CNT_W'(1) && r_pix != C_PIX_LAST) begin
            w_hold_next = i_pix_data;
          end
        end
      end

      default: begin
        w_state_next = S_IDLE;
        w_busy_next  = 1'b0;
      end
    endcase

    w_out_next = (w_state_next == S_SEND) &&
                 (w_cnt_next < (w_shift_next[23] ? C_T1H : C_T0H));
  end

  assign o_pix_addr = r_addr;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_out      = r_out;

endmodule

// File: tb/tb_rgb_pl9823_chain.sv
// Randomized bench for rgb_pl9823_chain: two instances (2 LEDs and 1 LED) against a cycle-indexed waveform model.
module tb_rgb_pl9823_chain;
  localparam int B  = 10;
  localparam int T0 = 2;
  localparam int T1 = 7;
  localparam int R  = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_a, start_b;
  logic [0:0]  addr_a, addr_b;
  logic [23:0] data_a, data_b;
  logic        busy_a, busy_b, done_a, done_b, out_a, out_b;

  logic [23:0] mem_a [0:1];
  logic [23:0] mem_b [0:1];
  logic [23:0] fr    [0:1];

  rgb_pl9823_chain #(.NUM_LEDS(2), .BIT_CYC(B), .T0H_CYC(T0), .T1H_CYC(T1), .RESET_CYC(R)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a), .o_pix_addr(addr_a), .i_pix_data(data_a),
    .o_busy(busy_a), .o_done(done_a), .o_out(out_a));

  rgb_pl9823_chain #(.NUM_LEDS(1), .BIT_CYC(B), .T0H_CYC(T0), .T1H_CYC(T1), .RESET_CYC(R)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b), .o_pix_addr(addr_b), .i_pix_data(data_b),
    .o_busy(busy_b), .o_done(done_b), .o_out(out_b));

  // Synchronous colour store, read latency 1.
  always_ff @(posedge clk) begin
    data_a <= mem_a[addr_a];
    data_b <= mem_b[addr_b];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: t = cycles after the START-accept edge.
  function automatic int frame_len(input int n);
    return R + n * 24 * B;
  endfunction

  function automatic logic exp_out(input int t, input int n);
    int s, p, j, c;
    logic b;
    if (t < R || t >= frame_len(n)) return 1'b0;
    s = t - R;
    p = s / (24 * B);
    j = (s / B) % 24;
    c = s % B;
    b = fr[p][23 - j];
    return (c < (b ? T1 : T0));
  endfunction

  function automatic int exp_addr(input int t, input int n);
    int s, p, j;
    if (t < R || t >= frame_len(n)) return 0;
    s = t - R;
    p = s / (24 * B);
    j = (s / B) % 24;
    return (j == 23 && p < n - 1) ? p + 1 : p;
  endfunction

  task automatic check_cycle(input int t, input int n);
    logic o, bz, d;
    logic [0:0] a;
    o  = (n == 2) ? out_a  : out_b;
    bz = (n == 2) ? busy_a : busy_b;
    d  = (n == 2) ? done_a : done_b;
    a  = (n == 2) ? addr_a : addr_b;
    check_val($sformatf("out n=%0d t=%0d", n, t),  {31'b0, o},  {31'b0, exp_out(t, n)});
    check_val($sformatf("busy n=%0d t=%0d", n, t), {31'b0, bz}, {31'b0, (t < frame_len(n))});
    check_val($sformatf("done n=%0d t=%0d", n, t), {31'b0, d},  {31'b0, (t == frame_len(n))});
    check_val($sformatf("addr n=%0d t=%0d", n, t), {31'b0, a},  exp_addr(t, n));
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, " out_a"},  {31'b0, out_a},  0);
    check_val({tag, " busy_a"}, {31'b0, busy_a}, 0);
    check_val({tag, " done_a"}, {31'b0, done_a}, 0);
    check_val({tag, " addr_a"}, {31'b0, addr_a}, 0);
    check_val({tag, " out_b"},  {31'b0, out_b},  0);
    check_val({tag, " busy_b"}, {31'b0, busy_b}, 0);
  endtask

  // hold=1 keeps START high through DONE; abort_at>=0 applies reset mid-frame.
  task automatic run_frame(input int n, input bit hold, input int abort_at);
    int bad0;
    bad0 = n_bad;
    mem_a[0] = fr[0];
    mem_a[1] = fr[1];
    mem_b[0] = fr[0];
    mem_b[1] = fr[1];
    @(negedge clk);
    if (n == 2) start_a = 1'b1; else start_b = 1'b1;
    for (int t = 0; t <= frame_len(n) + 3; t++) begin
      @(negedge clk);
      if (!hold || t == frame_len(n)) begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
      check_cycle(t, n);
      if (t == abort_at) begin
        #1 rst = 1'b1;
        #1;
        check_val("rst async out",  {31'b0, out_a},  0);
        check_val("rst async busy", {31'b0, busy_a}, 0);
        check_val("rst async addr", {31'b0, addr_a}, 0);
        check_val("rst async done", {31'b0, done_a}, 0);
        start_a = 1'b0;
        start_b = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        $display("frame n=%0d data=%06h_%06h aborted at t=%0d", n, fr[0], fr[1], t);
        return;
      end
    end
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      check_cycle(frame_len(n) + 4 + k, n);
    end
    $display("frame n=%0d data=%06h_%06h hold=%0d errors=%0d", n, fr[0], fr[1], hold, n_bad - bad0);
  endtask

  initial begin
    rst     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
      fr[i]    = '0;
    end
    repeat (3) @(negedge clk);
    check_idle("in reset");
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k % 10 == 9) check_idle($sformatf("idle k=%0d", k));
    end
    $display("idle after reset checked");

    fr[0] = 24'hFF0000;
    fr[1] = 24'h000001;
    run_frame(2, 1'b0, -1);

    fr[0] = $urandom;
    fr[1] = $urandom;
    run_frame(2, 1'b1, -1);

    fr[0] = 24'hFF0000;
    fr[1] = 24'h000001;
    run_frame(2, 1'b0, 100);
    repeat (5) @(negedge clk);
    check_idle("after abort");
    run_frame(2, 1'b0, -1);

    for (int i = 0; i < 3; i++) begin
      fr[0] = $urandom;
      fr[1] = $urandom;
      run_frame(2, 1'b0, -1);
    end

    fr[0] = 24'hAAAAAA;
    fr[1] = 24'h000000;
    run_frame(1, 1'b0, -1);
    fr[0] = $urandom;
    run_frame(1, 1'b1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
